// File: rtl/seq_pkg.sv
// seq_pkg: shared types and constants for the instruction sequencer.
// Holds the FSM state encoding, the opcode values, the program memory depth
// and the watchdog limit, plus small helpers for decoding instruction words.
package seq_pkg;

  // Sequencer FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_GAP   = 3'd3,
    ST_HALT  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  // Opcode field values, word layout is [7:6] opcode, [5:3] X, [2:0] Y.
  localparam logic [1:0] OP_MV  = 2'b00;
  localparam logic [1:0] OP_MVI = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  localparam int MEM_DEPTH  = 32;
  localparam int WDOG_LIMIT = 15;

  // True when the word is an mvi, i.e. it is followed by an immediate.
  function automatic logic is_mvi(input logic [7:0] word);
    return (word[7:6] == OP_MVI);
  endfunction

  // Number of program words an instruction occupies (mvi carries its immediate).
  function automatic logic [5:0] pc_step(input logic [7:0] word);
    logic [5:0] step;
    case (word[7:6])
      OP_MV, OP_ADD, OP_SUB: step = 6'd1;
      OP_MVI:                step = 6'd2;
      default:               step = 6'd1;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/prog_mem.sv
// prog_mem: 32x8 program store for the sequencer.
// One synchronous write port, two combinational read ports (instruction word
// and the following word for mvi immediates). Contents are deliberately not
// reset so a program survives a sequencer reset.
module prog_mem
  import seq_pkg::*;
(
  input  logic       Clock,
  input  logic       we,
  input  logic [4:0] waddr,
  input  logic [7:0] wdata,
  input  logic [4:0] raddr_a,
  input  logic [4:0] raddr_b,
  output logic [7:0] rdata_a,
  output logic [7:0] rdata_b
);

  logic [7:0] mem_r [MEM_DEPTH];

  // Synchronous write of one program word.
  always_ff @(posedge Clock) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata_a = mem_r[raddr_a];
  assign rdata_b = mem_r[raddr_b];

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: feeds a stored program word-by-word to a simple processor
// using a Run/Done handshake. Each instruction is presented for one ISSUE
// cycle, held through WAIT until Done, followed by a one-cycle Run=0 GAP.
// Optional build macro SEQ_WATCHDOG_EN adds a WAIT-state watchdog that traps
// into ERR (Error=1) after 15 cycles without Done; only Reset leaves ERR.
module instr_sequencer
  import seq_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic       LoadEn,
  input  logic [4:0] LoadAddr,
  input  logic [7:0] LoadData,
  input  logic [5:0] ProgLen,
  input  logic       Done,
  output logic [7:0] DIN,
  output logic       Run,
  output logic [5:0] PC,
  output logic       Busy,
  output logic       Halted,
  output logic [7:0] InstrCount,
  output logic       Error
);

  state_e     state_r;
  logic [5:0] pc_r;
  logic [5:0] prog_len_r;
  logic [7:0] instr_cnt_r;
  logic [7:0] word_s;
  logic [7:0] imm_s;
  logic [7:0] din_s;
  logic       we_s;
  logic [4:0] imm_addr_s;

`ifdef SEQ_WATCHDOG_EN
  logic [3:0] wdog_r;
  logic       err_r;
`endif

  // Program loads are only accepted while no program is executing.
  assign we_s = LoadEn && !Reset &&
                ((state_r == ST_IDLE) || (state_r == ST_HALT) || (state_r == ST_ERR));

  // Immediate address wraps within the 32-word store; PC itself never wraps.
  assign imm_addr_s = pc_r[4:0] + 5'd1;

  prog_mem u_prog_mem (
    .Clock   (Clock),
    .we      (we_s),
    .waddr   (LoadAddr),
    .wdata   (LoadData),
    .raddr_a (pc_r[4:0]),
    .raddr_b (imm_addr_s),
    .rdata_a (word_s),
    .rdata_b (imm_s)
  );

  // Sequencer FSM: PC, latched program length, retired count and watchdog.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r     <= ST_IDLE;
      pc_r        <= 6'd0;
      prog_len_r  <= 6'd0;
      instr_cnt_r <= 8'd0;
`ifdef SEQ_WATCHDOG_EN
      wdog_r      <= 4'd0;
      err_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE, ST_HALT: begin
          if (Start) begin
            pc_r       <= 6'd0;
            prog_len_r <= ProgLen;
            state_r    <= (ProgLen == 6'd0) ? ST_HALT : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state_r <= ST_WAIT;
`ifdef SEQ_WATCHDOG_EN
          wdog_r  <= 4'd0;
`endif
        end
        ST_WAIT: begin
          if (Done) begin
            pc_r        <= pc_r + pc_step(word_s);
            instr_cnt_r <= instr_cnt_r + 8'd1;
            state_r     <= ST_GAP;
          end
`ifdef SEQ_WATCHDOG_EN
          else if (wdog_r == 4'(WDOG_LIMIT - 1)) begin
            state_r <= ST_ERR;
            err_r   <= 1'b1;
          end else begin
            wdog_r <= wdog_r + 4'd1;
          end
`endif
        end
        ST_GAP: begin
          state_r <= (pc_r >= prog_len_r) ? ST_HALT : ST_ISSUE;
        end
        ST_ERR: begin
          state_r <= ST_ERR;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Data word presented to the processor; zero whenever Run is low.
  always_comb begin
    din_s = 8'h00;
    case (state_r)
      ST_ISSUE: din_s = word_s;
      ST_WAIT: begin
        if (is_mvi(word_s)) begin
          din_s = imm_s;
        end else begin
          din_s = word_s;
        end
      end
      default: din_s = 8'h00;
    endcase
  end

  assign DIN        = din_s;
  assign Run        = (state_r == ST_ISSUE) || (state_r == ST_WAIT);
  assign Busy       = (state_r == ST_ISSUE) || (state_r == ST_WAIT) || (state_r == ST_GAP);
  assign Halted     = (state_r == ST_HALT);
  assign PC         = pc_r;
  assign InstrCount = instr_cnt_r;

`ifdef SEQ_WATCHDOG_EN
  assign Error = err_r;
`else
  assign Error = 1'b0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed scoreboard bench for instr_sequencer.
// Stimulus pushes the DIN word expected on every Run=1 cycle into a queue;
// a monitor process pops and compares on each falling edge.
module tb_instr_sequencer;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic       LoadEn = 1'b0;
  logic [4:0] LoadAddr = 5'd0;
  logic [7:0] LoadData = 8'h00;
  logic [5:0] ProgLen = 6'd0;
  logic       Done = 1'b0;
  logic [7:0] DIN;
  logic       Run;
  logic [5:0] PC;
  logic       Busy;
  logic       Halted;
  logic [7:0] InstrCount;
  logic       Error;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_word;

  instr_sequencer dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start      (Start),
    .LoadEn     (LoadEn),
    .LoadAddr   (LoadAddr),
    .LoadData   (LoadData),
    .ProgLen    (ProgLen),
    .Done       (Done),
    .DIN        (DIN),
    .Run        (Run),
    .PC         (PC),
    .Busy       (Busy),
    .Halted     (Halted),
    .InstrCount (InstrCount),
    .Error      (Error)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic load(input logic [4:0] a, input logic [7:0] d);
    LoadEn = 1'b1; LoadAddr = a; LoadData = d;
    step();
    LoadEn = 1'b0;
  endtask

  task automatic start(input logic [5:0] n);
    ProgLen = n; Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  // Called in the ISSUE cycle; returns in the GAP cycle after Done.
  task automatic exec_instr(input logic [7:0] di, input logic [7:0] dw, input int nwait);
    exp_q.push_back(di);
    for (int i = 0; i < nwait; i++) exp_q.push_back(dw);
    Done = 1'b0;
    step();
    LoadEn = 1'b0; Start = 1'b0;
    for (int i = 1; i <= nwait; i++) begin
      Done = (i == nwait);
      step();
    end
    Done = 1'b0;
  endtask

  task automatic gap_to_issue();
    chk("gap_run", 32'(Run), 32'd0);
    step();
    chk("issue_run", 32'(Run), 32'd1);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_pc", 32'(PC), 32'd0);
    chk("rst_cnt", 32'(InstrCount), 32'd0);
    chk("rst_run", 32'(Run), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_halted", 32'(Halted), 32'd0);
    chk("rst_error", 32'(Error), 32'd0);
    chk("rst_din", 32'(DIN), 32'd0);

    fork
      forever begin
        @(negedge Clock);
        if (Run === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_run act=%0h exp=none", DIN);
          end else begin
            mon_word = exp_q.pop_front();
            chk("din_run", 32'(DIN), 32'(mon_word));
          end
        end else begin
          chk("din_idle", 32'(DIN), 32'd0);
        end
      end
    join_none

    // mvi R1, 5 as a two-word program
    load(5'd0, 8'h48);
    load(5'd1, 8'h05);
    start(6'd2);
    chk("t1_busy", 32'(Busy), 32'd1);
    exec_instr(8'h48, 8'h05, 2);
    chk("t1_pc", 32'(PC), 32'd2);
    chk("t1_cnt", 32'(InstrCount), 32'd1);
    chk("t1_gap_busy", 32'(Busy), 32'd1);
    chk("t1_gap_run", 32'(Run), 32'd0);
    step();
    chk("t1_halted", 32'(Halted), 32'd1);
    chk("t1_halt_busy", 32'(Busy), 32'd0);

    // mv, add, sub; loads/Start/ProgLen changes while running must be ignored
    do_reset();
    load(5'd0, 8'h0A);
    load(5'd1, 8'h8A);
    load(5'd2, 8'hCA);
    start(6'd3);
    LoadEn = 1'b1; LoadAddr = 5'd1; LoadData = 8'hFF; Start = 1'b1; ProgLen = 6'd0;
    exec_instr(8'h0A, 8'h0A, 1);
    gap_to_issue();
    exec_instr(8'h8A, 8'h8A, 2);
    gap_to_issue();
    exec_instr(8'hCA, 8'hCA, 2);
    chk("t2_pc", 32'(PC), 32'd3);
    chk("t2_cnt", 32'(InstrCount), 32'd3);
    step();
    chk("t2_halted", 32'(Halted), 32'd1);

    // Zero-length program halts immediately
    start(6'd0);
    chk("t3_halted", 32'(Halted), 32'd1);
    chk("t3_run", 32'(Run), 32'd0);
    chk("t3_busy", 32'(Busy), 32'd0);
    step();
    chk("t3_halted2", 32'(Halted), 32'd1);

    // mvi at address 31 takes immediate from address 0
    do_reset();
    load(5'd0, 8'hAA);
    for (int a = 1; a < 31; a++) load(5'(a), 8'h09);
    load(5'd31, 8'h48);
    start(6'd32);
    for (int a = 0; a < 31; a++) begin
      exec_instr((a == 0) ? 8'hAA : 8'h09, (a == 0) ? 8'hAA : 8'h09, 1);
      gap_to_issue();
    end
    chk("t4_pc31", 32'(PC), 32'd31);
    exec_instr(8'h48, 8'hAA, 1);
    chk("t4_pc", 32'(PC), 32'd33);
    chk("t4_cnt", 32'(InstrCount), 32'd32);
    step();
    chk("t4_halted", 32'(Halted), 32'd1);

    // mvi whose immediate lies beyond ProgLen still executes
    load(5'd0, 8'h48);
    load(5'd1, 8'h05);
    start(6'd1);
    exec_instr(8'h48, 8'h05, 1);
    chk("t5_pc", 32'(PC), 32'd2);
    chk("t5_cnt", 32'(InstrCount), 32'd33);
    step();
    chk("t5_halted", 32'(Halted), 32'd1);

    // Reset in WAIT wins over Done/Start/LoadEn and keeps memory
    start(6'd2);
    exp_q.push_back(8'h48);
    exp_q.push_back(8'h05);
    step();
    Reset = 1'b1; Done = 1'b1; Start = 1'b1;
    LoadEn = 1'b1; LoadAddr = 5'd0; LoadData = 8'h00;
    step();
    Reset = 1'b0; Done = 1'b0; Start = 1'b0; LoadEn = 1'b0;
    chk("t6_run", 32'(Run), 32'd0);
    chk("t6_pc", 32'(PC), 32'd0);
    chk("t6_cnt", 32'(InstrCount), 32'd0);
    chk("t6_busy", 32'(Busy), 32'd0);
    chk("t6_halted", 32'(Halted), 32'd0);
    start(6'd2);
    exec_instr(8'h48, 8'h05, 1);
    chk("t6_pc2", 32'(PC), 32'd2);
    chk("t6_cnt2", 32'(InstrCount), 32'd1);
    step();
    chk("t6_halted2", 32'(Halted), 32'd1);

`ifdef SEQ_WATCHDOG_EN
    // Watchdog trips after 15 WAIT cycles without Done
    start(6'd2);
    exp_q.push_back(8'h48);
    for (int i = 0; i < 15; i++) exp_q.push_back(8'h05);
    Done = 1'b0;
    step();
    for (int i = 1; i < 15; i++) step();
    chk("t7_err_early", 32'(Error), 32'd0);
    chk("t7_run_w15", 32'(Run), 32'd1);
    step();
    chk("t7_err", 32'(Error), 32'd1);
    chk("t7_run", 32'(Run), 32'd0);
    chk("t7_busy", 32'(Busy), 32'd0);
    chk("t7_halted", 32'(Halted), 32'd0);
    start(6'd2);
    step();
    chk("t7_err_hold", 32'(Error), 32'd1);
    chk("t7_run_hold", 32'(Run), 32'd0);
    do_reset();
    chk("t7_err_clr", 32'(Error), 32'd0);
    chk("t7_run_clr", 32'(Run), 32'd0);
`else
    // Without the watchdog WAIT holds indefinitely
    start(6'd2);
    exec_instr(8'h48, 8'h05, 20);
    chk("t7_err", 32'(Error), 32'd0);
    chk("t7_pc", 32'(PC), 32'd2);
    step();
    chk("t7_halted", 32'(Halted), 32'd1);
`endif

    step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
